bitvec_encoder: RTL and testbench

BITVEC_ENCODER -- requirements
Module: bitvec_encoder

---
 rtl/bitvec_encoder.sv | 88 ++++++++
 tb/tb_bitvec_encoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bitvec_encoder.sv
// Bit-vector to index-stream encoder: each set bit of an accepted 8-bit vector becomes one 3-bit index beat.
// Latency 1 (accept -> first beat), 1 beat/cycle; outputs hold while out_ready=0, no accept until the last beat retires.
module bitvec_encoder #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       out_empty
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic       empty_q, empty_d;
  logic [2:0] sel_idx;
  logic       single_bit;

  // Priority pick: the last match in loop order wins, so scan toward the favoured end.
  always_comb begin
    sel_idx = 3'd0;
    if (LOW_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (mask_q[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (mask_q[i]) sel_idx = 3'(i);
      end
    end
  end

  assign single_bit = (mask_q != 8'd0) && ((mask_q & (mask_q - 8'd1)) == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      empty_q <= empty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mask_d  = in_vec;
          empty_d = (in_vec == 8'd0);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          mask_d = mask_q & ~(8'd1 << sel_idx);
          if (out_last) begin
            state_d = IDLE;
            empty_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An all-zero vector still produces one beat, flagged by empty_q.
  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    out_valid = (state_q == EMIT);
    out_idx   = out_valid ? sel_idx : 3'd0;
    out_last  = out_valid && (empty_q || single_bit);
    out_empty = out_valid && empty_q;
  end

endmodule

// File: tb/tb_bitvec_encoder.sv
// Directed bench for bitvec_encoder: one instance per priority order, shared stimulus.
module tb_bitvec_encoder;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic [7:0] in_vec;
  logic       rdy_lo, vld_lo, last_lo, empty_lo;
  logic       rdy_hi, vld_hi, last_hi, empty_hi;
  logic [2:0] idx_lo, idx_hi;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  bitvec_encoder #(.LOW_FIRST(1'b1)) u_lo (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_lo), .in_vec(in_vec),
    .out_valid(vld_lo), .out_ready(out_ready), .out_idx(idx_lo), .out_last(last_lo),
    .out_empty(empty_lo)
  );

  bitvec_encoder #(.LOW_FIRST(1'b0)) u_hi (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_hi), .in_vec(in_vec),
    .out_valid(vld_hi), .out_ready(out_ready), .out_idx(idx_hi), .out_last(last_hi),
    .out_empty(empty_hi)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_lo(input string tag, input logic [2:0] idx, input logic last, input logic empty);
    check({tag, ".valid"}, {7'd0, vld_lo}, 8'd1);
    check({tag, ".idx"}, {5'd0, idx_lo}, {5'd0, idx});
    check({tag, ".last"}, {7'd0, last_lo}, {7'd0, last});
    check({tag, ".empty"}, {7'd0, empty_lo}, {7'd0, empty});
  endtask

  task automatic beat_hi(input string tag, input logic [2:0] idx, input logic last, input logic empty);
    check({tag, ".valid"}, {7'd0, vld_hi}, 8'd1);
    check({tag, ".idx"}, {5'd0, idx_hi}, {5'd0, idx});
    check({tag, ".last"}, {7'd0, last_hi}, {7'd0, last});
    check({tag, ".empty"}, {7'd0, empty_hi}, {7'd0, empty});
  endtask

  initial begin
    logic [2:0] a4_lo [3];
    logic [2:0] a4_hi [3];
    a4_lo = '{3'd2, 3'd5, 3'd7};
    a4_hi = '{3'd7, 3'd5, 3'd2};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = 8'h00;
    step();
    step();
    check("rst.in_ready", {7'd0, rdy_lo}, 8'd0);
    check("rst.out_valid", {7'd0, vld_lo}, 8'd0);
    check("rst.out_idx", {5'd0, idx_lo}, 8'd0);
    check("rst.out_last", {7'd0, last_lo}, 8'd0);
    check("rst.out_empty", {7'd0, empty_lo}, 8'd0);
    reset = 1'b0;
    #1;
    check("rst.in_ready_after", {7'd0, rdy_lo}, 8'd1);

    // 8'b1010_0100, both priority orders, out_ready held high
    in_valid = 1'b1; in_vec = 8'hA4; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_lo($sformatf("a4lo%0d", i), a4_lo[i], i == 2, 1'b0);
      beat_hi($sformatf("a4hi%0d", i), a4_hi[i], i == 2, 1'b0);
      check($sformatf("a4.in_ready%0d", i), {7'd0, rdy_lo}, 8'd0);
      step();
    end
    check("a4.done_valid", {7'd0, vld_lo}, 8'd0);
    check("a4.done_ready", {7'd0, rdy_lo}, 8'd1);

    // all-zero vector
    in_valid = 1'b1; in_vec = 8'h00;
    step();
    in_valid = 1'b0;
    beat_lo("zero_lo", 3'd0, 1'b1, 1'b1);
    beat_hi("zero_hi", 3'd0, 1'b1, 1'b1);
    step();
    check("zero.done_valid", {7'd0, vld_lo}, 8'd0);
    check("zero.done_ready", {7'd0, rdy_lo}, 8'd1);

    // 8'h81 with 3 stall cycles on the first beat
    in_valid = 1'b1; in_vec = 8'h81; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_lo($sformatf("stall%0d", i), 3'd0, 1'b0, 1'b0);
      if (i == 3) out_ready = 1'b1;
      step();
    end
    beat_lo("stall_end", 3'd7, 1'b1, 1'b0);
    step();
    check("stall.done_valid", {7'd0, vld_lo}, 8'd0);

    // 8'hFF with 8'h10 waiting on the input throughout
    in_valid = 1'b1; in_vec = 8'hFF;
    step();
    in_vec = 8'h10;
    for (int i = 0; i < 8; i++) begin
      beat_lo($sformatf("ff%0d", i), 3'(i), i == 7, 1'b0);
      beat_hi($sformatf("ffhi%0d", i), 3'(7 - i), i == 7, 1'b0);
      check($sformatf("ff.in_ready%0d", i), {7'd0, rdy_lo}, 8'd0);
      step();
    end
    check("ff.gap_valid", {7'd0, vld_lo}, 8'd0);
    check("ff.gap_ready", {7'd0, rdy_lo}, 8'd1);
    step();
    in_valid = 1'b0;
    beat_lo("next10", 3'd4, 1'b1, 1'b0);
    step();
    check("next10.done_valid", {7'd0, vld_lo}, 8'd0);

    // reset mid-vector after two beats
    in_valid = 1'b1; in_vec = 8'hFF;
    step();
    in_valid = 1'b0;
    beat_lo("mid0", 3'd0, 1'b0, 1'b0);
    step();
    beat_lo("mid1", 3'd1, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check("mid.rst_valid", {7'd0, vld_lo}, 8'd0);
    check("mid.rst_ready", {7'd0, rdy_lo}, 8'd0);
    reset = 1'b0;
    #1;
    check("mid.ready_after", {7'd0, rdy_lo}, 8'd1);
    step();
    check("mid.no_beat", {7'd0, vld_lo}, 8'd0);
    in_valid = 1'b1; in_vec = 8'h02;
    step();
    in_valid = 1'b0;
    beat_lo("after02", 3'd1, 1'b1, 1'b0);
    step();
    check("after02.done_valid", {7'd0, vld_lo}, 8'd0);
    check("after02.done_ready", {7'd0, rdy_lo}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
